// File: rtl/comparator_4b.sv
// comparator_4b: registered magnitude comparator with 7485-style cascade inputs
module comparator_4b #(
  parameter int WIDTH = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             out_valid,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less
);
  logic gt, lt, ne, nxt_gt, nxt_eq, nxt_lt;
  // On a tie the lower-order stage decides; eq_in is implied when gt_in and lt_in are both 0
  always_comb begin
    gt = SIGNED ? ($signed(A) > $signed(B)) : (A > B);
    lt = SIGNED ? ($signed(A) < $signed(B)) : (A < B);
    ne = A != B;
    nxt_gt = ne ? gt : gt_in;
    nxt_lt = ne ? lt : (!gt_in && lt_in);
    nxt_eq = !ne && !gt_in && !lt_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      A_greater <= 1'b0;
      A_equal   <= 1'b0;
      A_less    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        A_greater <= nxt_gt;
        A_equal   <= nxt_eq;
        A_less    <= nxt_lt;
      end
    end
  end
  logic unused_eq_in;
  assign unused_eq_in = eq_in;
endmodule

// File: tb/tb_comparator_4b.sv
// tb_comparator_4b: randomized and directed checks of unsigned and signed comparator instances
module tb_comparator_4b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic gi = 1'b0, ei = 1'b1, li = 1'b0;
  logic ov_u, g_u, e_u, l_u, ov_s, g_s, e_s, l_s;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  comparator_4b #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .gt_in(gi), .eq_in(ei), .lt_in(li),
    .out_valid(ov_u), .A_greater(g_u), .A_equal(e_u), .A_less(l_u));
  comparator_4b #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .gt_in(gi), .eq_in(ei), .lt_in(li),
    .out_valid(ov_s), .A_greater(g_s), .A_equal(e_s), .A_less(l_s));
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // reference: {greater, equal, less} from integer values and cascade priority
  function automatic logic [2:0] model(input logic [3:0] x, input logic [3:0] y,
                                       input logic g, input logic l, input bit sgn);
    int vx, vy;
    vx = (sgn && x[3]) ? int'(x) - 16 : int'(x);
    vy = (sgn && y[3]) ? int'(y) - 16 : int'(y);
    if (vx > vy) return 3'b100;
    if (vx < vy) return 3'b001;
    if (g) return 3'b100;
    if (l) return 3'b001;
    return 3'b010;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  typedef struct {logic [3:0] a, b; logic g, e, l; logic [2:0] eu, es; string tag;} vec_t;
  vec_t dirs[$];
  initial begin
    dirs.push_back('{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b010, 3'b010, "zero"});
    dirs.push_back('{4'b1001, 4'b0110, 1'b0, 1'b1, 1'b0, 3'b100, 3'b001, "9v6"});
    dirs.push_back('{4'b0101, 4'b1110, 1'b0, 1'b1, 1'b0, 3'b001, 3'b100, "5v14"});
    dirs.push_back('{4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0, 3'b010, 3'b010, "tie_eq"});
    dirs.push_back('{4'b1010, 4'b1010, 1'b1, 1'b0, 1'b0, 3'b100, 3'b100, "tie_gt"});
    dirs.push_back('{4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1, 3'b001, 3'b001, "tie_lt"});
    dirs.push_back('{4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, 3'b010, 3'b010, "tie_none"});
    dirs.push_back('{4'b1010, 4'b1010, 1'b1, 1'b0, 1'b1, 3'b100, 3'b100, "tie_gtlt"});
    dirs.push_back('{4'b0011, 4'b0010, 1'b0, 1'b0, 1'b1, 3'b100, 3'b100, "casc_ign"});
    dirs.push_back('{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b100, 3'b001, "ext"});
    step();
    check("rst_u", {ov_u, g_u, e_u, l_u}, 4'b0000);
    check("rst_s", {ov_s, g_s, e_s, l_s}, 4'b0000);
    rst = 1'b0;
    foreach (dirs[i]) begin
      a = dirs[i].a; b = dirs[i].b; gi = dirs[i].g; ei = dirs[i].e; li = dirs[i].l;
      in_valid = 1'b1;
      step();
      check({dirs[i].tag, "_u"}, {ov_u, g_u, e_u, l_u}, {1'b1, dirs[i].eu});
      check({dirs[i].tag, "_s"}, {ov_s, g_s, e_s, l_s}, {1'b1, dirs[i].es});
    end
    rst = 1'b1;
    step();
    check("rst_valid_u", {ov_u, g_u, e_u, l_u}, 4'b0000);
    check("rst_valid_s", {ov_s, g_s, e_s, l_s}, 4'b0000);
    rst = 1'b0;
    a = 4'b1001; b = 4'b0110; gi = 1'b0; ei = 1'b1; li = 1'b0;
    step();
    check("post_rst_u", {ov_u, g_u, e_u, l_u}, 4'b1100);
    check("post_rst_s", {ov_s, g_s, e_s, l_s}, 4'b1001);
    in_valid = 1'b0;
    a = 4'b0000; b = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_u", {ov_u, g_u, e_u, l_u}, 4'b0100);
      check("hold_s", {ov_s, g_s, e_s, l_s}, 4'b0001);
    end
    in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [2:0] c;
      a = 4'($urandom);
      b = (n % 4 == 0) ? a : 4'($urandom);
      c = 3'($urandom);
      gi = c[2]; ei = c[1]; li = c[0];
      step();
      check("rand_u", {ov_u, g_u, e_u, l_u}, {1'b1, model(a, b, gi, li, 1'b0)});
      check("rand_s", {ov_s, g_s, e_s, l_s}, {1'b1, model(a, b, gi, li, 1'b1)});
      check("onehot_u", 4'($countones({g_u, e_u, l_u})), 4'd1);
      check("onehot_s", 4'($countones({g_s, e_s, l_s})), 4'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
